data_sram_resp: RTL
===================

# data_sram_resp

Data-side responder for the CPU's SRAM-style data port. It sits at the far end of `data_sram_en/wen/addr/wdata/rdata`, opposite the core's memory stage. It holds a synchronous word-addressed RAM with byte-enable writes and a small memory-mapped register window: LEDs, synchronized switches, a free-running timer and a scratch register. Read data is returned with a fixed one-cycle latency.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: RAM depth is 2^ADDR_WIDTH 32-bit words.
- `MMIO_BASE`, 16'h1faf: value of `data_sram_addr[31:16]` that selects the register window.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `data_sram_en`  in  1  request valid this cycle.
- `data_sram_wen`  in  4  byte write enables; bit i covers `wdata[8i+7:8i]`; 0 means read.
- `data_sram_addr`  in  32  byte address; the core has already masked bits [31:29] to 0.
- `data_sram_wdata`  in  32  write data.
- `data_sram_rdata`  out  32  registered read data.
- `led`  out  16  LED register contents.
- `switch`  in  8  asynchronous switch inputs.

## Operation
- Region select when `en`=1:
  - MMIO when `addr[31:16]==MMIO_BASE`.
  - Otherwise RAM, word index `addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses alias (wrap) modulo RAM size.
- `addr[1:0]` is ignored everywhere; accesses are word-aligned.
- RAM write (`en`=1, `wen`≠0): only enabled bytes are updated at the edge. Other bytes keep their value.
- RAM read (`en`=1, `wen`=0): word at index is registered into `rdata`.
- MMIO offsets, `addr[15:0]`:
  - 0x0000 LED: RW, low 16 bits; reads return {16'h0, led}.
  - 0x0004 SWITCH: RO; reads return {24'h0, switch after a 2-flop synchronizer}.
  - 0x0008 TIMER: RW, 32-bit.
  - 0x000C SCRATCH: RW, 32-bit.
  - Any other offset reads 0; writes to it are dropped.
- Byte enables apply to every RW register. For LED, `wen[3:2]` are ignored.
- Timer:
  - Increments by 1 every cycle, wrapping 0xFFFFFFFF→0.
  - In a cycle with a timer write, the new value is the byte-merged old value and `wdata`. No increment is applied that cycle; counting resumes the next cycle.
- Writes to SWITCH are ignored.
- `en`=0: no state change except timer increment and the synchronizer; `rdata` holds.
- Write cycles (`wen`≠0) leave `rdata` unchanged.
- Reset values: `rdata`=0, `led`=0, timer=0, scratch=0, both synchronizer stages=0. RAM contents are not reset.
- Reset asserted mid-access: the access is lost, and outputs go to reset values immediately (asynchronous).

## Timing
- Read latency is 1 cycle: a read presented with `en` in cycle N gives `rdata` valid after edge N, through cycle N+1, until the next read edge.
- Back-to-back reads may issue every cycle. There is no stall and no handshake beyond `en`.
- Write then read of the same word in consecutive cycles: the read returns the newly written data. The write commits at edge N; the read samples at edge N+1.
- Timer read returns the value held immediately before the sampling edge.
- The switch value is visible to a read 2 edges after `switch` changes (synchronizer latency). The read adds 1 more cycle to `rdata`.
- `led` is a direct register output; it changes one edge after the write is presented.

## Test plan
- Reset, then `en`=0 for 5 cycles → `rdata`=0 and `led`=0; a timer read issued in cycle 5 returns 5.
- Write 0xDEADBEEF to 0x00000010 with `wen`=4'hF, then write 0x000000AA with `wen`=4'h1, then read 0x00000010 → `rdata`=0xDEADBEAA one cycle after the read.
- `ADDR_WIDTH`=12: write 0x12345678 to 0x00004000, then read 0x00000000 → 0x12345678 (alias).
- Write 0x0000A5A5 to 0x1faf0000 → `led`=16'hA5A5 after one edge. Then read 0x1faf0000 → 0x0000A5A5. Then read 0x1faf0010 → 0.
- Write 0xFFFFFFFE to TIMER, then read two cycles later → 0x00000000 (one increment to 0xFFFFFFFF, one wrap).
- Drive `switch`=8'h3C → a SWITCH read issued 2 cycles later returns 0x3C. Assert `rst` mid-read → `rdata` goes to 0 asynchronously.

Source files
------------

// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: word RAM with byte-enable writes plus an MMIO
// register window (LED, synchronized switches, free-running timer, scratch).
module data_sram_resp #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [15:0] MMIO_BASE  = 16'h1faf
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] idx;
  logic [13:0]           reg_sel;
  logic                  is_mmio;
  logic                  is_wr;
  logic                  is_rd;
  logic                  ram_we;
  logic                  led_we;
  logic                  tmr_we;
  logic                  scr_we;
  logic                  unused_addr;

  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [31:0] timer;
  logic [31:0] scratch;
  logic [31:0] mmio_rdata;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  assign idx         = data_sram_addr[ADDR_WIDTH+1:2];
  assign reg_sel     = data_sram_addr[15:2];
  assign is_mmio     = data_sram_addr[31:16] == MMIO_BASE;
  assign is_wr       = data_sram_en && (data_sram_wen != 4'h0);
  assign is_rd       = data_sram_en && (data_sram_wen == 4'h0);
  assign ram_we      = is_wr && !is_mmio;
  assign led_we      = is_wr && is_mmio && (reg_sel == 14'd0);
  assign tmr_we      = is_wr && is_mmio && (reg_sel == 14'd2);
  assign scr_we      = is_wr && is_mmio && (reg_sel == 14'd3);
  assign unused_addr = ^data_sram_addr[1:0];

  always_comb begin
    mmio_rdata = 32'h0;
    case (reg_sel)
      14'd0:   mmio_rdata = {16'h0, led};
      14'd1:   mmio_rdata = {24'h0, sw_sync};
      14'd2:   mmio_rdata = timer;
      14'd3:   mmio_rdata = scratch;
      default: mmio_rdata = 32'h0;
    endcase
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we && data_sram_wen[i])
        mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sram_rdata <= 32'h0;
    end else if (is_rd) begin
      data_sram_rdata <= is_mmio ? mmio_rdata : mem[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= 8'h0;
      sw_sync <= 8'h0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= 16'h0;
    end else if (led_we) begin
      for (int i = 0; i < 2; i++)
        if (data_sram_wen[i]) led[8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end
  end

  // A timer write replaces that cycle's increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= 32'h0;
    end else if (tmr_we) begin
      timer <= merge(timer, data_sram_wdata, data_sram_wen);
    end else begin
      timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch <= 32'h0;
    end else if (scr_we) begin
      scratch <= merge(scratch, data_sram_wdata, data_sram_wen);
    end
  end

endmodule
